vpu_cmd_dispatch: RTL

//  Upstream command front-end for matrix_unit. Accepts 32-bit instruction words from the host,

---
 rtl/vpu_cmd_dispatch.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/vpu_cmd_dispatch.sv
// Host command front-end for matrix_unit: word FIFO, header/operand decode, go pulse, busy handshake.
// Optional feature macro: VPU_CMD_TIMEOUT_EN (WAIT-state timeout, err_timeout flag).
module vpu_cmd_dispatch #(
  parameter int DEPTH    = 16,
  parameter int BUSY_LAT = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              cmd_data,
  input  logic                     cmd_vld,
  output logic                     cmd_rdy,
  input  logic                     busy,
  input  logic                     obj_mem_full,
  output logic                     go,
  output logic [3:0]               gmt_op,
  output logic [3:0]               gmt_code,
  output logic [4:0]               obj_num,
  output logic [1:0]               obj_type,
  output logic [7:0]               obj_color,
  output logic signed [15:0]       v0,
  output logic signed [15:0]       v1,
  output logic signed [15:0]       v2,
  output logic signed [15:0]       v3,
  output logic signed [15:0]       v4,
  output logic signed [15:0]       v5,
  output logic signed [15:0]       v6,
  output logic signed [15:0]       v7,
  output logic                     idle,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     err_full,
`ifdef VPU_CMD_TIMEOUT_EN
  output logic                     err_timeout,
`endif
  input  logic                     err_clr
);

  // state  | meaning
  // IDLE   | waiting for a header word
  // OPND   | loading operand words into v regs
  // ISSUE  | decide go or drop (create with object memory full)
  // GUARD  | busy ignored for BUSY_LAT cycles after go
  // WAIT   | waiting for matrix_unit busy to drop
  typedef enum logic [2:0] {S_IDLE, S_OPND, S_ISSUE, S_GUARD, S_WAIT} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (BUSY_LAT >= 2) ? $clog2(BUSY_LAT) : 1;

  state_t            state, state_nxt;
  logic [31:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [31:0]       head;
  logic              push, pop, empty, full;
  logic              go_set, drop;
  logic [1:0]        opnd_idx, opnd_last;
  logic [GW-1:0]     guard_cnt;
  logic [15:0]       vreg [8];

`ifdef VPU_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     tmr;
  logic              tmo;
`endif

  assign empty   = (fifo_cnt == '0);
  assign full    = (fifo_cnt == (AW+1)'(DEPTH));
  assign cmd_rdy = !full;
  assign push    = cmd_vld && cmd_rdy;
  assign head    = mem[rd_ptr];
  assign idle    = (state == S_IDLE) && empty;

  assign v0 = vreg[0];
  assign v1 = vreg[1];
  assign v2 = vreg[2];
  assign v3 = vreg[3];
  assign v4 = vreg[4];
  assign v5 = vreg[5];
  assign v6 = vreg[6];
  assign v7 = vreg[7];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    go_set    = 1'b0;
    drop      = 1'b0;
`ifdef VPU_CMD_TIMEOUT_EN
    tmo       = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = head[8] ? S_OPND : S_ISSUE;
        end
      end
      S_OPND: begin
        if (!empty) begin
          pop = 1'b1;
          if (opnd_idx == opnd_last) state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if ((gmt_op == 4'd0) && obj_mem_full) begin
          drop      = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          go_set    = 1'b1;
          state_nxt = S_GUARD;
        end
      end
      S_GUARD: begin
        if (guard_cnt == '0) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!busy) begin
          state_nxt = S_IDLE;
`ifdef VPU_CMD_TIMEOUT_EN
        end else if (tmr == '0) begin
          tmo       = 1'b1;
          state_nxt = S_IDLE;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      go        <= 1'b0;
      gmt_op    <= '0;
      gmt_code  <= '0;
      obj_num   <= '0;
      obj_type  <= '0;
      obj_color <= '0;
      opnd_idx  <= '0;
      opnd_last <= '0;
      guard_cnt <= '0;
      err_full  <= 1'b0;
      for (int i = 0; i < 8; i++) vreg[i] <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      go <= go_set;

      if ((state == S_IDLE) && pop) begin
        gmt_op    <= head[31:28];
        gmt_code  <= head[27:24];
        obj_num   <= head[23:19];
        obj_type  <= head[18:17];
        obj_color <= head[16:9];
        opnd_last <= head[7:6];
        opnd_idx  <= '0;
      end

      if ((state == S_OPND) && pop) begin
        vreg[{opnd_idx, 1'b0}] <= head[15:0];
        vreg[{opnd_idx, 1'b1}] <= head[31:16];
        opnd_idx               <= opnd_idx + 1'b1;
      end

      if (go_set)
        guard_cnt <= GW'(BUSY_LAT - 1);
      else if ((state == S_GUARD) && (guard_cnt != '0))
        guard_cnt <= guard_cnt - 1'b1;

      // Clear wins over a same-cycle drop.
      if (err_clr)   err_full <= 1'b0;
      else if (drop) err_full <= 1'b1;
    end
  end

`ifdef VPU_CMD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr         <= '0;
      err_timeout <= 1'b0;
    end else begin
      if ((state == S_GUARD) && (guard_cnt == '0))
        tmr <= TW'(TIMEOUT - 1);
      else if ((state == S_WAIT) && (tmr != '0))
        tmr <= tmr - 1'b1;

      if (err_clr)  err_timeout <= 1'b0;
      else if (tmo) err_timeout <= 1'b1;
    end
  end
`endif

endmodule
